// File: rtl/cmplx_mult_iter.sv
// Iterative complex multiplier: one shared signed multiplier, four cycles per result.
// Computes A*B or A*conj(B) with full-precision 2W+1 bit outputs and a valid/ready handshake.
module cmplx_mult_iter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] ar,
    input  logic [W-1:0] ai,
    input  logic [W-1:0] br,
    input  logic [W-1:0] bi,
    input  logic         conj,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [2*W:0] Pr,
    output logic [2*W:0] Pi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);
    localparam int P = 2 * W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [1:0]     step_q;
    logic [W-1:0]   ar_q, ai_q, br_q, bi_q;
    logic           conj_q;
    logic [P-1:0]   acc_r_q, acc_i_q;
    logic [P-1:0]   pr_q, pi_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [W-1:0]          ma, mb;
    logic signed [2*W-1:0] ma_x, mb_x, prod;
    logic [P-1:0]          prod_x, addend, sum_d;
    logic                  neg;

    // Step order: ar*br, ai*bi, ar*bi, ai*br
    always_comb begin
        ma = ai_q;
        mb = br_q;
        unique case (step_q)
            2'd0: begin ma = ar_q; mb = br_q; end
            2'd1: begin ma = ai_q; mb = bi_q; end
            2'd2: begin ma = ar_q; mb = bi_q; end
            default: begin ma = ai_q; mb = br_q; end
        endcase
    end

    assign ma_x   = {{W{ma[W-1]}}, ma};
    assign mb_x   = {{W{mb[W-1]}}, mb};
    assign prod   = ma_x * mb_x;
    assign prod_x = {prod[2*W-1], prod};
    assign neg    = (step_q == 2'd1 && !conj_q) || (step_q == 2'd2 && conj_q);
    assign addend = neg ? -prod_x : prod_x;
    // Steps 0-1 build the real part, steps 2-3 the imaginary part
    assign sum_d  = (step_q[1] ? acc_i_q : acc_r_q) + addend;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            conj_q      <= 1'b0;
            acc_r_q     <= '0;
            acc_i_q     <= '0;
            pr_q        <= '0;
            pi_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ar_q    <= ar;
                        ai_q    <= ai;
                        br_q    <= br;
                        bi_q    <= bi;
                        conj_q  <= conj;
                        acc_r_q <= '0;
                        acc_i_q <= '0;
                        step_q  <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    step_q <= step_q + 2'd1;
                    if (!step_q[1]) acc_r_q <= sum_d;
                    else            acc_i_q <= sum_d;
                    if (step_q == 2'd3) begin
                        pr_q        <= acc_r_q;
                        pi_q        <= sum_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        step_q      <= 2'd0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && rst;
    assign Pr        = pr_q;
    assign Pi        = pi_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_cmplx_mult_iter.sv
// Bench for cmplx_mult_iter: W=12 directed scenarios plus W=8/W=16 streaming.
// Expected results come from a reference model pushed to per-instance scoreboards.
module tb_cmplx_mult_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [11:0] ar, ai, br, bi;
    logic        cj, iv, ir, ov, ordy, bsy;
    logic [24:0] pr, pi;

    logic [7:0]  ar8, ai8, br8, bi8;
    logic        cj8, iv8, ir8, ov8, ordy8, bsy8;
    logic [16:0] pr8, pi8;

    logic [15:0] ar16, ai16, br16, bi16;
    logic        cj16, iv16, ir16, ov16, ordy16, bsy16;
    logic [32:0] pr16, pi16;

    int total = 0;
    int passed = 0;
    logic [49:0] q12[$];
    logic [33:0] q8[$];
    logic [65:0] q16[$];

    cmplx_mult_iter #(.W(12)) dut (
        .clk(clk), .rst(rst), .ar(ar), .ai(ai), .br(br), .bi(bi),
        .conj(cj), .in_valid(iv), .in_ready(ir), .Pr(pr), .Pi(pi),
        .out_valid(ov), .out_ready(ordy), .busy(bsy));
    cmplx_mult_iter #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .ar(ar8), .ai(ai8), .br(br8), .bi(bi8),
        .conj(cj8), .in_valid(iv8), .in_ready(ir8), .Pr(pr8), .Pi(pi8),
        .out_valid(ov8), .out_ready(ordy8), .busy(bsy8));
    cmplx_mult_iter #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .ar(ar16), .ai(ai16), .br(br16), .bi(bi16),
        .conj(cj16), .in_valid(iv16), .in_ready(ir16), .Pr(pr16), .Pi(pi16),
        .out_valid(ov16), .out_ready(ordy16), .busy(bsy16));

    function automatic longint ref_r(longint a_r, a_i, b_r, b_i, bit c);
        return c ? a_r * b_r + a_i * b_i : a_r * b_r - a_i * b_i;
    endfunction

    function automatic longint ref_i(longint a_r, a_i, b_r, b_i, bit c);
        return c ? a_i * b_r - a_r * b_i : a_r * b_i + a_i * b_r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int a_r, a_i, b_r, b_i, input bit c, input string nm);
        logic [49:0] exp;
        int n;
        n = 0;
        while (ir !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (ir !== 1'b1) $display("FAIL %s accept: in_ready=%b want 1", nm, ir);
        else passed++;
        ar = 12'(a_r); ai = 12'(a_i); br = 12'(b_r); bi = 12'(b_i);
        cj = c;
        iv = 1'b1;
        q12.push_back({25'(ref_r(a_r, a_i, b_r, b_i, c)), 25'(ref_i(a_r, a_i, b_r, b_i, c))});
        tick();
        iv = 1'b0;
        ar = 12'($urandom); ai = 12'($urandom);
        br = 12'($urandom); bi = 12'($urandom);
        cj = ~c;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (ov !== 1'b0 || bsy !== 1'b1)
                $display("FAIL %s mul E%0d: out_valid=%b busy=%b want 0 1", nm, k, ov, bsy);
            else passed++;
        end
        tick();
        total++;
        if (ov !== 1'b1 || bsy !== 1'b0)
            $display("FAIL %s latency: out_valid=%b busy=%b want 1 0", nm, ov, bsy);
        else passed++;
        if (q12.size() > 0) begin
            exp = q12.pop_front();
            total++;
            if ({pr, pi} !== exp)
                $display("FAIL %s result: got Pr=%0d Pi=%0d want Pr=%0d Pi=%0d", nm,
                         $signed(pr), $signed(pi), $signed(exp[49:25]), $signed(exp[24:0]));
            else passed++;
        end
        if (ordy) begin
            tick();
            total++;
            if (ov !== 1'b0 || ir !== 1'b1)
                $display("FAIL %s transfer: out_valid=%b in_ready=%b want 0 1", nm, ov, ir);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        iv = 1'b1; ordy = 1'b1;
        ar = 12'd5; ai = 12'd6; br = 12'd7; bi = 12'd8; cj = 1'b0;
        iv8 = 1'b0; iv16 = 1'b0; ordy8 = 1'b1; ordy16 = 1'b1;
        ar8 = '0; ai8 = '0; br8 = '0; bi8 = '0; cj8 = 1'b0;
        ar16 = '0; ai16 = '0; br16 = '0; bi16 = '0; cj16 = 1'b0;
        tick(); tick(); tick();
        total++;
        if (ir !== 1'b0 || ov !== 1'b0 || bsy !== 1'b0)
            $display("FAIL reset ctrl: in_ready=%b out_valid=%b busy=%b want 0 0 0", ir, ov, bsy);
        else passed++;
        total++;
        if (pr !== 25'd0 || pi !== 25'd0)
            $display("FAIL reset data: Pr=%0d Pi=%0d want 0 0", $signed(pr), $signed(pi));
        else passed++;
        iv = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (ir !== 1'b1) $display("FAIL reset release: in_ready=%b want 1", ir);
        else passed++;
    endtask

    task automatic test_basic;
        run_op(3, 4, 5, 6, 1'b0, "basic_mul");
        run_op(3, 4, 5, 6, 1'b1, "basic_conj");
        run_op(-2048, -2048, -2048, -2048, 1'b0, "min_mul");
        run_op(-2048, -2048, -2048, -2048, 1'b1, "min_conj");
        run_op(2047, -2048, -2048, 2047, 1'b0, "mixed_mul");
    endtask

    task automatic test_stall;
        logic [49:0] hold;
        int bad;
        ordy = 1'b0;
        run_op(-7, 100, 33, -2048, 1'b1, "stall");
        hold = {pr, pi};
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            iv = 1'($urandom);
            ar = 12'($urandom); ai = 12'($urandom);
            br = 12'($urandom); bi = 12'($urandom);
            tick();
            if (ov !== 1'b1 || ir !== 1'b0 || {pr, pi} !== hold) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL stall hold: %0d bad cycles want 0", bad);
        else passed++;
        iv = 1'b0;
        ordy = 1'b1;
        tick();
        total++;
        if (ov !== 1'b0 || ir !== 1'b1)
            $display("FAIL stall release: out_valid=%b in_ready=%b want 0 1", ov, ir);
        else passed++;
        tick();
        total++;
        if ({pr, pi} !== hold)
            $display("FAIL retain: Pr=%0d Pi=%0d want Pr=%0d Pi=%0d", $signed(pr), $signed(pi),
                     $signed(hold[49:25]), $signed(hold[24:0]));
        else passed++;
    endtask

    task automatic test_abort;
        int bad;
        ar = 12'd11; ai = 12'd22; br = 12'd33; bi = 12'd44; cj = 1'b0;
        iv = 1'b1;
        tick();
        iv = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (ov !== 1'b0 || bsy !== 1'b0 || pr !== 25'd0 || pi !== 25'd0)
            $display("FAIL abort: out_valid=%b busy=%b Pr=%0d Pi=%0d want 0 0 0 0",
                     ov, bsy, $signed(pr), $signed(pi));
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (ir !== 1'b1) $display("FAIL abort release: in_ready=%b want 1", ir);
        else passed++;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ov !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL abort discard: %0d cycles with out_valid want 0", bad);
        else passed++;
        run_op(-100, 57, 300, -1, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back;
        logic [33:0] e8;
        logic [65:0] e16;
        int cyc, last8, last16, n8, n16, bad8, bad16;
        cyc = 0; last8 = -1; last16 = -1; n8 = 0; n16 = 0; bad8 = 0; bad16 = 0;
        iv8 = 1'b1; iv16 = 1'b1; ordy8 = 1'b1; ordy16 = 1'b1;
        for (int k = 0; k < 130; k++) begin
            if (ov8 === 1'b1) begin
                if (q8.size() == 0) bad8++;
                else begin
                    e8 = q8.pop_front();
                    total++;
                    if ({pr8, pi8} !== e8)
                        $display("FAIL w8 result: got Pr=%0d Pi=%0d want Pr=%0d Pi=%0d",
                                 $signed(pr8), $signed(pi8), $signed(e8[33:17]), $signed(e8[16:0]));
                    else passed++;
                end
                if (last8 >= 0 && cyc - last8 != 6) bad8++;
                last8 = cyc;
                n8++;
            end
            if (ov16 === 1'b1) begin
                if (q16.size() == 0) bad16++;
                else begin
                    e16 = q16.pop_front();
                    total++;
                    if ({pr16, pi16} !== e16)
                        $display("FAIL w16 result: got Pr=%0d Pi=%0d want Pr=%0d Pi=%0d",
                                 $signed(pr16), $signed(pi16), $signed(e16[65:33]), $signed(e16[32:0]));
                    else passed++;
                end
                if (last16 >= 0 && cyc - last16 != 6) bad16++;
                last16 = cyc;
                n16++;
            end
            ar8 = 8'($urandom); ai8 = 8'($urandom); br8 = 8'($urandom); bi8 = 8'($urandom);
            cj8 = 1'($urandom);
            ar16 = 16'($urandom); ai16 = 16'($urandom); br16 = 16'($urandom); bi16 = 16'($urandom);
            cj16 = 1'($urandom);
            if (ir8 === 1'b1)
                q8.push_back({
                    17'(ref_r(longint'($signed(ar8)), longint'($signed(ai8)),
                              longint'($signed(br8)), longint'($signed(bi8)), cj8)),
                    17'(ref_i(longint'($signed(ar8)), longint'($signed(ai8)),
                              longint'($signed(br8)), longint'($signed(bi8)), cj8))});
            if (ir16 === 1'b1)
                q16.push_back({
                    33'(ref_r(longint'($signed(ar16)), longint'($signed(ai16)),
                              longint'($signed(br16)), longint'($signed(bi16)), cj16)),
                    33'(ref_i(longint'($signed(ar16)), longint'($signed(ai16)),
                              longint'($signed(br16)), longint'($signed(bi16)), cj16))});
            tick();
            cyc++;
        end
        iv8 = 1'b0; iv16 = 1'b0;
        total++;
        if (bad8 != 0 || n8 < 20 || q8.size() > 1)
            $display("FAIL w8 stream: bad=%0d results=%0d pending=%0d want 0 >=20 <=1",
                     bad8, n8, q8.size());
        else passed++;
        total++;
        if (bad16 != 0 || n16 < 20 || q16.size() > 1)
            $display("FAIL w16 stream: bad=%0d results=%0d pending=%0d want 0 >=20 <=1",
                     bad16, n16, q16.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
